ex_stage: RTL
=============

# ex_stage

Execute stage of the 5-stage MIPS pipeline. Holds the ID/EX and EX/MEM pipeline registers and performs operand selection and the 32-bit ALU operation. Operand selection is driven by the forwarding unit's ASel/BSel codes. The block exports the ID/EX source registers and the EX/MEM destination/control that the forwarding unit consumes.

## Interface
- WIDTH, 32, datapath width
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- freeze  input  1  hold both pipeline registers (memory wait)
- bubble  input  1  load a NOP into ID/EX (load-use stall or branch flush)
- idRegWrite, idMemRead, idMemWrite, idMemToReg, idAluSrc, idRegDst  input  1 each  decode control
- idAluOp  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 NOR, 110 XOR, 111 SLL-by-imm[10:6]
- idRead1, idRead2, idImm  input  WIDTH  register-file operands, sign-extended immediate
- idRs, idRt, idRd  input  5  register specifiers
- ASel, BSel  input  2  forwarding codes: 0 register value, 1 exMemAluResult, 2 wbData, 3 treated as 0
- wbData  input  WIDTH  MEM/WB write-back value
- exRs, exRt  output  5  ID/EX Rs/Rt (to forwarding)
- exMemRd  output  5  EX/MEM destination
- exMemRegWrite, exMemMemRead, exMemMemWrite, exMemMemToReg  output  1 each
- exMemAluResult, exMemWriteData  output  WIDTH
- exMemOverflow  output  1  present only with EX_OVERFLOW_EN

## Operation
- ID/EX stage: the destination is idRegDst ? idRd : idRt, and it is registered.
- Operand A = mux(ASel) of {idEx read1, exMemAluResult, wbData}.
- Forwarded B = mux(BSel) of {idEx read2, exMemAluResult, wbData}.
- ALU B = idEx aluSrc ? idEx imm : forwarded B.
- exMemWriteData = forwarded B. Store data always uses the forwarded value, never the immediate.
- Arithmetic wraps modulo 2^WIDTH.
- SLT is signed and yields 0 or 1, zero-extended.
- SLL shifts operand B (rt) by the registered imm[10:6].
- Bubble: the ID/EX control bits (regWrite, memRead, memWrite, memToReg) load 0; Rs, Rt and Rd load 0; data fields are don't-care. A bubble leaves exRs and exRt at 0, so the forwarding unit matches nothing.
- Priority, highest first: rst > freeze > bubble > normal load.
- freeze holds ID/EX and EX/MEM unchanged, including any pending bubble.
- ASel/BSel are combinational inputs sampled in the same cycle that exRs/exRt are presented. The block adds no register on them.

## Timing
- Reset: every output and every internal register is 0, including exMemOverflow.
- Latency: ID inputs presented before edge N appear in ID/EX after N. The ALU result and forwarded store data appear on the EX/MEM outputs after edge N+1.
- Throughput: one instruction per cycle when freeze=0.
- Back-to-back dependency: with ASel=1, an instruction in EX uses the result that the previous instruction registered into EX/MEM at the preceding edge.
- bubble and freeze asserted together: freeze wins; neither register changes.
- rst asserted mid-stream: both registers clear at that edge. Instructions in flight are lost with no partial writes; the cleared state has regWrite=0 and memWrite=0.
- ASel=3 or BSel=3: that operand behaves as code 0.

## Configuration
- EX_OVERFLOW_EN defined:
  - exMemOverflow is present.
  - Signed overflow on ADD or SUB sets exMemOverflow=1 and forces exMemRegWrite=0 for that instruction. The wrapped result is still registered.
- Overflow is never flagged for other ops or for bubbles.
- EX_OVERFLOW_EN undefined:
  - The port is absent.
  - ADD and SUB wrap silently, and regWrite passes through unchanged.

## Test plan
- Reset: hold rst 2 cycles with random ID inputs -> all outputs 0. First instruction after release (ADD 5+7) gives exMemAluResult=12 two edges later.
- EX/MEM forwarding:
  - Instruction 1 is ADD r3=r1(10)+r2(20).
  - Next is SUB r4=r3-r1 with ASel=1 and stale idRead1=0.
  - Expected: 30 then 20, exMemRd 3 then 4.
- WB forwarding and store data:
  - SW with BSel=2, wbData=0xDEADBEEF, idAluSrc=1, imm=8, read1=0x100.
  - Expected: exMemAluResult=0x108, exMemWriteData=0xDEADBEEF, exMemMemWrite=1.
- Bubble vs freeze:
  - bubble alone: next exMemRegWrite=0, exRs=exRt=0.
  - bubble and freeze together: all outputs are unchanged for that cycle.
  - freeze held 3 cycles: outputs stay constant, then resume in order.
- ALU corners:
  - SLT(-1, 1) gives 1.
  - SLT(1, -1) gives 0.
  - ADD(0xFFFFFFFF, 1) gives 0.
  - NOR(0, 0) gives 0xFFFFFFFF.
  - SLL imm[10:6]=4 of 0x1 gives 0x10.
- EX_OVERFLOW_EN: ADD 0x7FFFFFFF+1 gives exMemAluResult=0x80000000, exMemOverflow=1, exMemRegWrite=0. With the macro undefined, the same instruction gives exMemRegWrite=1.

Source files
------------

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ID/EX and EX/MEM registers, forwarding muxes, 32-bit ALU
// Optional feature macro: EX_OVERFLOW_EN (signed ADD/SUB overflow flag that suppresses regWrite)
module ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             bubble,
  input  logic             idRegWrite,
  input  logic             idMemRead,
  input  logic             idMemWrite,
  input  logic             idMemToReg,
  input  logic             idAluSrc,
  input  logic             idRegDst,
  input  logic [2:0]       idAluOp,
  input  logic [WIDTH-1:0] idRead1,
  input  logic [WIDTH-1:0] idRead2,
  input  logic [WIDTH-1:0] idImm,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic [4:0]       idRd,
  input  logic [1:0]       ASel,
  input  logic [1:0]       BSel,
  input  logic [WIDTH-1:0] wbData,
  output logic [4:0]       exRs,
  output logic [4:0]       exRt,
  output logic [4:0]       exMemRd,
  output logic             exMemRegWrite,
  output logic             exMemMemRead,
  output logic             exMemMemWrite,
  output logic             exMemMemToReg,
  output logic [WIDTH-1:0] exMemAluResult,
  output logic [WIDTH-1:0] exMemWriteData
`ifdef EX_OVERFLOW_EN
  ,
  output logic             exMemOverflow
`endif
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  logic             idExRegWrite, idExMemRead, idExMemWrite, idExMemToReg, idExAluSrc;
  logic [2:0]       idExAluOp;
  logic [WIDTH-1:0] idExRead1, idExRead2, idExImm;
  logic [4:0]       idExRd;

  logic [WIDTH-1:0] opA, fwdB, aluB, aluResult;
  logic             exRegWrite;

  // ID/EX register: a bubble clears control and register specifiers so forwarding matches nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      idExRegWrite <= 1'b0;
      idExMemRead  <= 1'b0;
      idExMemWrite <= 1'b0;
      idExMemToReg <= 1'b0;
      idExAluSrc   <= 1'b0;
      idExAluOp    <= '0;
      idExRead1    <= '0;
      idExRead2    <= '0;
      idExImm      <= '0;
      exRs         <= '0;
      exRt         <= '0;
      idExRd       <= '0;
    end else if (!freeze) begin
      idExRegWrite <= idRegWrite & ~bubble;
      idExMemRead  <= idMemRead & ~bubble;
      idExMemWrite <= idMemWrite & ~bubble;
      idExMemToReg <= idMemToReg & ~bubble;
      idExAluSrc   <= idAluSrc;
      idExAluOp    <= idAluOp;
      idExRead1    <= idRead1;
      idExRead2    <= idRead2;
      idExImm      <= idImm;
      exRs         <= bubble ? 5'd0 : idRs;
      exRt         <= bubble ? 5'd0 : idRt;
      idExRd       <= bubble ? 5'd0 : (idRegDst ? idRd : idRt);
    end
  end

  // Forwarding muxes; code 3 falls back to the register value
  always_comb begin
    case (ASel)
      2'd1:    opA = exMemAluResult;
      2'd2:    opA = wbData;
      default: opA = idExRead1;
    endcase
    case (BSel)
      2'd1:    fwdB = exMemAluResult;
      2'd2:    fwdB = wbData;
      default: fwdB = idExRead2;
    endcase
    aluB = idExAluSrc ? idExImm : fwdB;
  end

  // ALU; SLL shifts the rt value by the shamt field held in imm[10:6]
  always_comb begin
    aluResult = '0;
    case (idExAluOp)
      OP_ADD: aluResult = opA + aluB;
      OP_SUB: aluResult = opA - aluB;
      OP_AND: aluResult = opA & aluB;
      OP_OR:  aluResult = opA | aluB;
      OP_SLT: aluResult = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(aluB))};
      OP_NOR: aluResult = ~(opA | aluB);
      OP_XOR: aluResult = opA ^ aluB;
      OP_SLL: aluResult = fwdB << idExImm[10:6];
      default: aluResult = '0;
    endcase
  end

`ifdef EX_OVERFLOW_EN
  logic idExValid;
  logic aluOverflow;

  // Tracks whether ID/EX holds a real instruction, so bubbles never flag overflow
  always_ff @(posedge clk) begin
    if (rst)
      idExValid <= 1'b0;
    else if (!freeze)
      idExValid <= ~bubble;
  end

  assign aluOverflow = idExValid & (aluResult[WIDTH-1] != opA[WIDTH-1]) &
                       (((idExAluOp == OP_ADD) && (opA[WIDTH-1] == aluB[WIDTH-1])) ||
                        ((idExAluOp == OP_SUB) && (opA[WIDTH-1] != aluB[WIDTH-1])));
  assign exRegWrite  = idExRegWrite & ~aluOverflow;

  // Overflow flag travels with its instruction into EX/MEM
  always_ff @(posedge clk) begin
    if (rst)
      exMemOverflow <= 1'b0;
    else if (!freeze)
      exMemOverflow <= aluOverflow;
  end
`else
  assign exRegWrite = idExRegWrite;
`endif

  // EX/MEM register: store data is always the forwarded rt value, never the immediate
  always_ff @(posedge clk) begin
    if (rst) begin
      exMemRd        <= '0;
      exMemRegWrite  <= 1'b0;
      exMemMemRead   <= 1'b0;
      exMemMemWrite  <= 1'b0;
      exMemMemToReg  <= 1'b0;
      exMemAluResult <= '0;
      exMemWriteData <= '0;
    end else if (!freeze) begin
      exMemRd        <= idExRd;
      exMemRegWrite  <= exRegWrite;
      exMemMemRead   <= idExMemRead;
      exMemMemWrite  <= idExMemWrite;
      exMemMemToReg  <= idExMemToReg;
      exMemAluResult <= aluResult;
      exMemWriteData <= fwdB;
    end
  end

endmodule
